// File: rtl/gcd_engine.sv
// gcd_engine: subtraction-based greatest-common-divisor engine.
// A start in IDLE loads both operands. Each CALC cycle then either
// subtracts the smaller working value from the larger one or finishes.
// A finished result is published for one DONE cycle, and the result
// registers keep it until the next completed computation.
module gcd_engine #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out,
   output logic [WIDTH-1:0] iter_cnt,
   output logic             zero_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic [WIDTH-1:0] iter_q, iter_d;
   logic             zerr_q, zerr_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ra_zero_s;
   logic             rb_zero_s;

   assign ra_zero_s = (ra_q == ZERO);
   assign rb_zero_s = (rb_q == ZERO);

   // Next-state, working-register and result computation for the FSM.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      cnt_d   = cnt_q;
      gcd_d   = gcd_q;
      iter_d  = iter_q;
      zerr_d  = zerr_q;
      case (state_q)
         S_IDLE: begin
            // start together with abort is treated as no request at all
            if (start && !abort) begin
               ra_d    = a_in;
               rb_d    = b_in;
               cnt_d   = ZERO;
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (abort) begin
               // result registers are deliberately left untouched
               state_d = S_IDLE;
            end else if (ra_zero_s || rb_zero_s) begin
               gcd_d   = ra_q | rb_q;
               iter_d  = cnt_q;
               zerr_d  = ra_zero_s && rb_zero_s;
               state_d = S_DONE;
            end else if (ra_q == rb_q) begin
               gcd_d   = ra_q;
               iter_d  = cnt_q;
               zerr_d  = 1'b0;
               state_d = S_DONE;
            end else if (ra_q > rb_q) begin
               // larger value is always the minuend, so no underflow
               ra_d  = ra_q - rb_q;
               cnt_d = cnt_q + ONE;
            end else begin
               rb_d  = rb_q - ra_q;
               cnt_d = cnt_q + ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // status flags track the state being entered so they register in step
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_CALC);
      done_d  = (state_d == S_DONE);
   end

   // State, working and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= ZERO;
         rb_q    <= ZERO;
         cnt_q   <= ZERO;
         gcd_q   <= ZERO;
         iter_q  <= ZERO;
         zerr_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         cnt_q   <= cnt_d;
         gcd_q   <= gcd_d;
         iter_q  <= iter_d;
         zerr_q  <= zerr_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign gcd_out  = gcd_q;
   assign iter_cnt = iter_q;
   assign zero_err = zerr_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: directed scenarios plus random operands checked
// against a Euclid (division/remainder) reference model.
module tb_gcd_engine;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [15:0] a_in, b_in;
   logic        ready, busy, done, zero_err;
   logic [15:0] gcd_out, iter_cnt;

   logic        rst8, start8, abort8;
   logic [7:0]  a8, b8;
   logic        ready8, busy8, done8, zerr8;
   logic [7:0]  gcd8, iter8;

   int tests = 0;
   int fails = 0;
   int done16_cnt = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a_in(a_in), .b_in(b_in), .ready(ready), .busy(busy), .done(done),
      .gcd_out(gcd_out), .iter_cnt(iter_cnt), .zero_err(zero_err)
   );

   gcd_engine #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .abort(abort8),
      .a_in(a8), .b_in(b8), .ready(ready8), .busy(busy8), .done(done8),
      .gcd_out(gcd8), .iter_cnt(iter8), .zero_err(zerr8)
   );

   // One-hot status monitor and done-pulse counter for both instances.
   always @(negedge clk) begin
      if (mon_en) begin
         tests++;
         if (!$onehot({ready, busy, done}) || !$onehot({ready8, busy8, done8})) begin
            fails++;
            $display("FAIL onehot: w16 rbd=%b%b%b w8 rbd=%b%b%b, required exactly one high",
                     ready, busy, done, ready8, busy8, done8);
         end
         if (done) done16_cnt++;
      end
   end

   assert property (@(posedge clk) disable iff (!mon_en) $onehot({ready, busy, done}))
      else $error("FAIL onehot assertion w16");

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: subtraction count derived from Euclid quotients.
   function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                   output int unsigned g, output int unsigned n);
      int unsigned q, r;
      n = 0;
      if (a == 0 || b == 0) begin
         g = a | b;
         return;
      end
      while (a != b) begin
         if (a > b) begin
            q = a / b; r = a % b;
            if (r == 0) begin n += q - 1; a = b; end
            else begin n += q; a = r; end
         end else begin
            q = b / a; r = b % a;
            if (r == 0) begin n += q - 1; b = a; end
            else begin n += q; b = r; end
         end
      end
      g = a;
   endfunction

   // Start a 16-bit computation and count edges (accept edge = 1) until done.
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit hold,
                        output int edges, output bit seen);
      start = 1'b1; abort = 1'b0; a_in = a; b_in = b;
      tick();
      edges = 1;
      seen  = 1'b0;
      if (!hold) start = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         if (done) begin seen = 1'b1; break; end
         tick();
         edges++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b1; a_in = 16'd5; b_in = 16'd9;
      rst8 = 1'b1; start8 = 1'b0; abort8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      tick(); tick();
      tests++;
      if ({ready, busy, done, gcd_out, iter_cnt, zero_err} !== {3'b100, 16'd0, 16'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: rbd=%b%b%b gcd=%0d iter=%0d zerr=%b, required 100/0/0/0",
                  ready, busy, done, gcd_out, iter_cnt, zero_err);
      end
      rst8 = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_first_start();
      int edges; bit seen;
      rst = 1'b0; abort = 1'b0;
      run16(16'd12, 16'd24, 1'b0, edges, seen);
      tests++;
      if (!seen || edges != 3 || gcd_out !== 16'd12 || iter_cnt !== 16'd1 || zero_err !== 1'b0) begin
         fails++;
         $display("FAIL first_start_12_24: seen=%b edges=%0d gcd=%0d iter=%0d zerr=%b, required 1/3/12/1/0",
                  seen, edges, gcd_out, iter_cnt, zero_err);
      end
      tick();
      tests++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL done_one_cycle: done=%b ready=%b, required 0/1", done, ready);
      end
   endtask

   task automatic test_zero_operands();
      int edges; bit seen;
      run16(16'd0, 16'd0, 1'b0, edges, seen);
      tests++;
      if (!seen || edges != 2 || gcd_out !== 16'd0 || iter_cnt !== 16'd0 || zero_err !== 1'b1) begin
         fails++;
         $display("FAIL zero_zero: seen=%b edges=%0d gcd=%0d iter=%0d zerr=%b, required 1/2/0/0/1",
                  seen, edges, gcd_out, iter_cnt, zero_err);
      end
      tick();
      run16(16'd0, 16'd7, 1'b0, edges, seen);
      tests++;
      if (!seen || edges != 2 || gcd_out !== 16'd7 || iter_cnt !== 16'd0 || zero_err !== 1'b0) begin
         fails++;
         $display("FAIL zero_seven: seen=%b edges=%0d gcd=%0d iter=%0d zerr=%b, required 1/2/7/0/0",
                  seen, edges, gcd_out, iter_cnt, zero_err);
      end
      tick();
      run16(16'd9, 16'd0, 1'b0, edges, seen);
      tests++;
      if (!seen || gcd_out !== 16'd9 || zero_err !== 1'b0) begin
         fails++;
         $display("FAIL nine_zero: seen=%b gcd=%0d zerr=%b, required 1/9/0", seen, gcd_out, zero_err);
      end
      tick();
   endtask

   task automatic test_width8();
      int edges;
      bit seen;
      start8 = 1'b1; a8 = 8'd255; b8 = 8'd1;
      tick();
      start8 = 1'b0;
      edges = 1; seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done8) begin seen = 1'b1; break; end
         tick();
         edges++;
      end
      tests++;
      if (!seen || edges != 256 || gcd8 !== 8'd1 || iter8 !== 8'd254 || zerr8 !== 1'b0) begin
         fails++;
         $display("FAIL w8_255_1: seen=%b edges=%0d gcd=%0d iter=%0d zerr=%b, required 1/256/1/254/0",
                  seen, edges, gcd8, iter8, zerr8);
      end
      tick();
      start8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
      tick();
      start8 = 1'b0;
      edges = 1; seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done8) begin seen = 1'b1; break; end
         tick();
         edges++;
      end
      tests++;
      if (!seen || edges != 2 || gcd8 !== 8'd255 || iter8 !== 8'd0) begin
         fails++;
         $display("FAIL w8_255_255: seen=%b edges=%0d gcd=%0d iter=%0d, required 1/2/255/0",
                  seen, edges, gcd8, iter8);
      end
      tick();
   endtask

   task automatic test_abort();
      int dc;
      logic [15:0] prev_gcd, prev_iter;
      prev_gcd = gcd_out; prev_iter = iter_cnt;
      // start with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1; a_in = 16'd48; b_in = 16'd18;
      tick();
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL start_with_abort: ready=%b busy=%b, required 1/0", ready, busy);
      end
      dc = done16_cnt;
      abort = 1'b0;
      tick();             // accept edge
      start = 1'b0;
      tick();             // first CALC edge
      abort = 1'b1;
      tick();             // second CALC edge aborts
      abort = 1'b0;
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0 || gcd_out !== prev_gcd || iter_cnt !== prev_iter) begin
         fails++;
         $display("FAIL abort_calc: ready=%b busy=%b gcd=%0d iter=%0d, required 1/0/%0d/%0d",
                  ready, busy, gcd_out, iter_cnt, prev_gcd, prev_iter);
      end
      repeat (6) tick();
      tests++;
      if (done16_cnt != dc || ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_no_done: done pulses=%0d ready=%b, required 0/1", done16_cnt - dc, ready);
      end
   endtask

   task automatic test_start_held();
      int edges; bit seen; int unsigned g, n;
      ref_gcd(48, 18, g, n);
      run16(16'd48, 16'd18, 1'b1, edges, seen);
      tests++;
      if (!seen || edges != int'(n) + 2 || gcd_out !== g[15:0] || iter_cnt !== n[15:0]) begin
         fails++;
         $display("FAIL start_held_48_18: seen=%b edges=%0d gcd=%0d iter=%0d, required 1/%0d/%0d/%0d",
                  seen, edges, gcd_out, iter_cnt, n + 2, g, n);
      end
      tick();
      tick();
      tests++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL start_not_queued: ready=%b busy=%b, required 1/0", ready, busy);
      end
   endtask

   task automatic test_reset_mid_calc();
      int dc; int edges; bit seen;
      start = 1'b1; a_in = 16'd100; b_in = 16'd75;
      tick();
      start = 1'b0;
      tick();
      dc = done16_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({ready, busy, done, gcd_out, iter_cnt, zero_err} !== {3'b100, 16'd0, 16'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid_calc: rbd=%b%b%b gcd=%0d iter=%0d zerr=%b, required 100/0/0/0",
                  ready, busy, done, gcd_out, iter_cnt, zero_err);
      end
      repeat (4) tick();
      tests++;
      if (done16_cnt != dc) begin
         fails++;
         $display("FAIL reset_no_done: done pulses=%0d, required 0", done16_cnt - dc);
      end
      run16(16'd100, 16'd75, 1'b0, edges, seen);
      tests++;
      if (!seen || gcd_out !== 16'd25 || iter_cnt !== 16'd3 || edges != 5) begin
         fails++;
         $display("FAIL restart_100_75: seen=%b gcd=%0d iter=%0d edges=%0d, required 1/25/3/5",
                  seen, gcd_out, iter_cnt, edges);
      end
      tick();
   endtask

   task automatic test_random();
      int edges; bit seen; int unsigned a, b, g, n;
      for (int k = 0; k < 40; k++) begin
         do begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            if (k % 8 == 0) a = $urandom_range(0, 200);
            ref_gcd(a, b, g, n);
         end while (n > 3000);
         run16(a[15:0], b[15:0], 1'b0, edges, seen);
         tests++;
         if (!seen || edges != int'(n) + 2 || gcd_out !== g[15:0] || iter_cnt !== n[15:0] ||
             zero_err !== (a == 0 && b == 0)) begin
            fails++;
            $display("FAIL random a=%0d b=%0d: seen=%b edges=%0d gcd=%0d iter=%0d zerr=%b, required 1/%0d/%0d/%0d",
                     a, b, seen, edges, gcd_out, iter_cnt, zero_err, n + 2, g, n);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_first_start();
      test_zero_operands();
      test_width8();
      test_abort();
      test_start_held();
      test_reset_mid_calc();
      test_random();
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
